// File: rtl/rx_bit_timer.sv
// Mid-bit sample timer for the UART receiver: one strobe per data bit plus the
// stop bit, then a single packet_done pulse. All outputs are registered.
module rx_bit_timer #(
    parameter int unsigned BP_BITS = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable_timer,
    input  logic [BP_BITS-1:0] bit_period,
    input  logic [3:0]         data_size,
    output logic               shift_strobe,
    output logic               packet_done,
    output logic               timer_busy,
    output logic [3:0]         bit_index
);

    localparam int unsigned CntW = BP_BITS + 1;

    typedef enum logic [2:0] {StIdle, StStart, StData, StDone, StRearm} state_e;

    state_e state_q, state_d;

    logic [BP_BITS-1:0] bp_q, bp_d;
    logic [3:0]         ds_q, ds_d;
    logic [CntW-1:0]    clk_cnt_q, clk_cnt_d;
    logic [3:0]         bit_index_q, bit_index_d;
    logic               strobe_q, strobe_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [BP_BITS-1:0] bp_clamped;
    logic [3:0]         ds_clamped;
    logic [CntW-1:0]    start_span;
    logic [CntW-1:0]    cnt_target;
    logic               timing;
    logic               cnt_hit;
    logic               last_strobe;

    assign bp_clamped = (bit_period < BP_BITS'(2)) ? BP_BITS'(2) : bit_period;
    assign ds_clamped = (data_size < 4'd5) ? 4'd5 :
                        (data_size > 4'd8) ? 4'd8 : data_size;

    // 1.5 bit periods: skip the start bit and land in the middle of data bit 0.
    assign start_span  = {1'b0, bp_q} + {2'b00, bp_q[BP_BITS-1:1]};
    assign cnt_target  = (state_q == StStart) ? start_span : {1'b0, bp_q};
    assign timing      = (state_q == StStart) || (state_q == StData);
    assign cnt_hit     = (clk_cnt_q == cnt_target);
    assign last_strobe = (bit_index_q == ds_q);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (enable_timer) state_d = StStart;
            end
            StStart: begin
                if (!enable_timer)  state_d = StIdle;
                else if (cnt_hit)   state_d = StData;
            end
            StData: begin
                if (!enable_timer)                state_d = StIdle;
                else if (cnt_hit && last_strobe)  state_d = StDone;
            end
            StDone: begin
                state_d = StRearm;
            end
            StRearm: begin
                if (!enable_timer) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output and datapath next values; abort wins over a strobe due on the same edge.
    always_comb begin
        bp_d        = bp_q;
        ds_d        = ds_q;
        clk_cnt_d   = clk_cnt_q;
        bit_index_d = bit_index_q;
        strobe_d    = timing && enable_timer && cnt_hit;
        done_d      = (state_q == StDone);
        busy_d      = (state_d == StStart) || (state_d == StData) || (state_d == StDone);

        if ((state_q == StIdle) && enable_timer) begin
            bp_d        = bp_clamped;
            ds_d        = ds_clamped;
            clk_cnt_d   = CntW'(1);
            bit_index_d = 4'd0;
        end else if (timing && enable_timer) begin
            if (cnt_hit) begin
                clk_cnt_d = CntW'(1);
                if (bit_index_q <= ds_q) bit_index_d = bit_index_q + 4'd1;
            end else begin
                clk_cnt_d = clk_cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_q        <= '0;
            ds_q        <= '0;
            clk_cnt_q   <= '0;
            bit_index_q <= '0;
            strobe_q    <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            bp_q        <= bp_d;
            ds_q        <= ds_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_index_q <= bit_index_d;
            strobe_q    <= strobe_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign shift_strobe = strobe_q;
    assign packet_done  = done_q;
    assign timer_busy   = busy_q;
    assign bit_index    = bit_index_q;

endmodule

// File: tb/tb_rx_bit_timer.sv
// Directed bench for rx_bit_timer: per-cycle comparison of strobe/done/busy/index
// against an edge-count model, plus hand-computed strobe totals per frame.
module tb_rx_bit_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_timer;
    logic [13:0] bit_period;
    logic [3:0]  data_size;
    logic        shift_strobe;
    logic        packet_done;
    logic        timer_busy;
    logic [3:0]  bit_index;

    int checks = 0;
    int errors = 0;

    rx_bit_timer #(.BP_BITS(14)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable_timer (enable_timer),
        .bit_period   (bit_period),
        .data_size    (data_size),
        .shift_strobe (shift_strobe),
        .packet_done  (packet_done),
        .timer_busy   (timer_busy),
        .bit_index    (bit_index)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int j, input logic [6:0] obs,
                         input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s j=%0d observed={stb,done,busy,idx}=%b expected=%b",
                   tag, j, obs, exp);
        end
    endtask

    // Expected {strobe, done, busy, bit_index} sampled just after edge E0+j.
    function automatic logic [6:0] expect_at(input int j, input int bp, input int ds,
                                             input int abort_at);
        int   s    = bp + bp / 2;
        int   last = s + ds * bp;
        int   idx  = 0;
        logic st   = 1'b0;
        logic dn;
        logic bz;
        for (int k = 1; k <= ds + 1; k++) begin
            int e = s + (k - 1) * bp;
            if (e <= j && e < abort_at) idx++;
            if (e == j && e < abort_at) st = 1'b1;
        end
        dn = (j == last + 1) && (last < abort_at);
        bz = (j <= last) && (j < abort_at);
        return {st, dn, bz, 4'(idx)};
    endfunction

    // Starts a frame from IDLE; edge E0 is the first edge after this call.
    task automatic run_frame(input string tag, input int bp_in, input int ds_in,
                             input int abort_at, input int n_cycles, input int change_at,
                             input int exp_strobes);
        int bp_eff = (bp_in < 2) ? 2 : bp_in;
        int ds_eff = (ds_in < 5) ? 5 : (ds_in > 8) ? 8 : ds_in;
        int nstb   = 0;
        bit_period   = 14'(bp_in);
        data_size    = 4'(ds_in);
        enable_timer = 1'b1;
        for (int j = 0; j < n_cycles; j++) begin
            tick();
            check(tag, j, {shift_strobe, packet_done, timer_busy, bit_index},
                  expect_at(j, bp_eff, ds_eff, abort_at));
            if (shift_strobe) nstb++;
            if (j == abort_at - 1) enable_timer = 1'b0;
            if (j == change_at) bit_period = 14'd20;
        end
        checks++;
        assert (nstb == exp_strobes) else begin
            errors++;
            $error("FAIL %s strobe_count observed=%0d expected=%0d", tag, nstb, exp_strobes);
        end
    endtask

    task automatic go_idle(input string tag);
        enable_timer = 1'b0;
        tick();
        tick();
        check(tag, 0, {shift_strobe, packet_done, timer_busy, 4'd0}, 7'd0);
    endtask

    initial begin
        rst          = 1'b1;
        enable_timer = 1'b0;
        bit_period   = 14'd10;
        data_size    = 4'd8;
        repeat (3) tick();
        check("reset", 0, {shift_strobe, packet_done, timer_busy, bit_index}, 7'd0);
        rst = 1'b0;
        tick();
        check("idle_after_reset", 0, {shift_strobe, packet_done, timer_busy, bit_index}, 7'd0);

        // T1: strobes at 15,25..95, done at 96
        run_frame("T1", 10, 8, 1000, 100, -1, 9);
        go_idle("T1_idle");

        // T2: first strobe at 16, then every 11, done at 72
        run_frame("T2", 11, 5, 1000, 80, -1, 6);
        go_idle("T2_idle");

        // T3: enable sampled low at E0+41, strobe due at 45 suppressed
        run_frame("T3", 10, 8, 41, 60, -1, 3);
        go_idle("T3_idle");

        // T4: bit_period changed mid-frame is ignored
        run_frame("T4", 10, 8, 1000, 100, 30, 9);
        go_idle("T4_idle");

        // T5: enable held high 50 clocks past done, then a one-cycle drop and rearm
        run_frame("T5a", 10, 8, 1000, 97 + 50, -1, 9);
        enable_timer = 1'b0;
        tick();
        check("T5_drop", 0, {shift_strobe, packet_done, timer_busy, 4'd0}, 7'd0);
        run_frame("T5b", 10, 8, 1000, 100, -1, 9);
        go_idle("T5_idle");

        // T6: asynchronous reset mid-frame clears everything at once
        run_frame("T6a", 10, 8, 1000, 50, -1, 4);
        #2;
        rst          = 1'b1;
        enable_timer = 1'b0;
        #1;
        check("T6_async_rst", 0, {shift_strobe, packet_done, timer_busy, bit_index}, 7'd0);
        tick();
        tick();
        rst = 1'b0;
        for (int j = 0; j < 20; j++) begin
            tick();
            check("T6_quiet", j, {shift_strobe, packet_done, timer_busy, bit_index}, 7'd0);
        end

        // Boundary clamps: bit_period 0/1 -> 2, data_size 12 -> 8, 3 -> 5
        run_frame("T6b_bp0", 0, 8, 1000, 30, -1, 9);
        go_idle("T6b_idle");
        run_frame("T6c_bp1_ds12", 1, 12, 1000, 30, -1, 9);
        go_idle("T6c_idle");
        run_frame("T6d_ds3", 2, 3, 1000, 20, -1, 6);
        go_idle("T6d_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
